// File: rtl/bus_pkg.sv
// Shared definitions for the strobe-bus read responder.
//   BUS_AW / BUS_DW : bus address / data widths
//   WAIT_CNT_W      : width of the wait-state down-counter (WAIT_STATES 0..15)
//   RD / WR         : rw encodings on the bus
//   state_t         : responder handshake states
package bus_pkg;

    localparam int unsigned BUS_AW     = 8;
    localparam int unsigned BUS_DW     = 16;
    localparam int unsigned WAIT_CNT_W = 4;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, cleared by asynchronous active-low reset.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low clear
//   i_inc   : increment request (ignored once all-ones is reached)
//   o_count : current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/bus_read_responder.sv
// Target-side responder for the 8-bit address / 16-bit data strobe bus.
// Serves reads from a local 256x16 array through an as/ds -> da four-phase
// handshake with WAIT_STATES idle cycles before da; the array is loaded
// through a separate config write port.
//   clk, rst               : clock, asynchronous active-low reset
//   addr, as, rw, ds       : bus request inputs
//   da, data               : data acknowledge and read data (valid while da=1)
//   cfg_we/addr/wdata      : config write port into the array
//   busy                   : high whenever the responder is not IDLE
//   rd_count, err_count    : saturating completed-read / error counters
module bus_read_responder
    import bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BUS_AW-1:0] addr,
    input  logic              as,
    input  logic              rw,
    input  logic              ds,
    output logic              da,
    output logic [BUS_DW-1:0] data,
    input  logic              cfg_we,
    input  logic [BUS_AW-1:0] cfg_addr,
    input  logic [BUS_DW-1:0] cfg_wdata,
    output logic              busy,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    logic [BUS_DW-1:0]     r_mem [DEPTH];

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [WAIT_CNT_W-1:0] w_cnt_nxt;
    logic [BUS_AW-1:0]     r_addr;
    logic                  r_rw;
    logic                  r_da;
    logic                  w_da_nxt;
    logic [BUS_DW-1:0]     r_data;
    logic [BUS_DW-1:0]     w_data_nxt;
    logic                  r_busy;
    logic                  w_capture;
    logic                  w_rd_inc;
    logic                  w_err_inc;

    // Array is deliberately not reset. A config write on the WAIT->ACK edge
    // lands after the comb read below, so the bus sees the old value.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            r_mem[cfg_addr] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rw    <= RD;
            r_da    <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_da    <= w_da_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            if (w_capture) begin
                r_addr <= addr;
                r_rw   <= rw;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_da_nxt    = r_da;
        w_data_nxt  = r_data;
        w_capture   = 1'b0;
        w_rd_inc    = 1'b0;
        w_err_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (as && ds) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = WAIT_LOAD;
                    w_capture   = 1'b1;
                end
            end
            WAIT: begin
                if (!as || !ds) begin
                    // Master withdrew the request before acknowledge.
                    w_state_nxt = IDLE;
                    w_err_inc   = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ACK;
                    w_da_nxt    = 1'b1;
                    if (r_rw == WR) begin
                        // Writes are not supported: full handshake, zero data.
                        w_data_nxt = '0;
                        w_err_inc  = 1'b1;
                    end else begin
                        w_data_nxt = r_mem[r_addr];
                        w_rd_inc   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - WAIT_CNT_W'(1);
                end
            end
            ACK: begin
                if (!ds) begin
                    w_state_nxt = IDLE;
                    w_da_nxt    = 1'b0;
                    w_data_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    sat_counter #(.WIDTH(CNT_W)) u_rd_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_rd_inc),
        .o_count (rd_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_inc   (w_err_inc),
        .o_count (err_count)
    );

    assign da   = r_da;
    assign data = r_data;
    assign busy = r_busy;

endmodule
